// File: rtl/cpu15_ram_arb.sv
// Arbitrates the CPU exec-stage port and the host port onto one shared data RAM.
// CPU has fixed priority; the host is forced through after HOST_MAX_WAIT lost arbitrations.
module cpu15_ram_arb #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_in,
    output logic              o_ram_wen,
    input  logic [DATA_W-1:0] i_ram_out,
    output logic              o_busy
);

    localparam int unsigned WaitW = $clog2(HOST_MAX_WAIT + 1);
    localparam int unsigned LatW  = $clog2(RD_LAT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(HOST_MAX_WAIT);
    localparam logic [LatW-1:0]  LatLast = LatW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cpu_armed;
    logic              r_host_armed;
    logic [WaitW-1:0]  r_wait_cnt;
    logic [LatW-1:0]   r_lat_cnt;
    logic              r_host_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_in;
    logic              r_ram_wen;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_host_rdata;

    logic w_cpu_elig;
    logic w_host_elig;
    logic w_host_pick;
    logic w_grant;
    logic w_sample;
    logic w_done;

    always_comb begin
        w_cpu_elig  = i_cpu_req & r_cpu_armed;
        w_host_elig = i_host_req & r_host_armed;
        w_host_pick = w_host_elig & (~w_cpu_elig | (r_wait_cnt == WaitMax));
        w_grant     = (r_state == StIdle) & (w_cpu_elig | w_host_elig);
        w_done      = (r_state == StDone);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_grant) w_state_nxt = StIssue;
            end
            StIssue: begin
                if (r_we) begin
                    w_state_nxt = StDone;
                end else if (RD_LAT == 1) begin
                    w_state_nxt = StDone;
                    w_sample    = 1'b1;
                end else begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (r_lat_cnt == LatLast) begin
                    w_state_nxt = StDone;
                    w_sample    = 1'b1;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cpu_armed  <= 1'b1;
            r_host_armed <= 1'b1;
            r_wait_cnt   <= '0;
            r_lat_cnt    <= '0;
            r_host_win   <= 1'b0;
            r_we         <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_in     <= '0;
            r_ram_wen    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A low REQ re-arms even on the DONE edge, so a requester that drops on ACK is ready again
            r_cpu_armed  <= ~i_cpu_req | (r_cpu_armed & ~(w_done & ~r_host_win));
            r_host_armed <= ~i_host_req | (r_host_armed & ~(w_done & r_host_win));
            r_ram_wen    <= 1'b0;
            if (w_grant) begin
                r_host_win <= w_host_pick;
                r_we       <= w_host_pick ? i_host_we : i_cpu_we;
                r_ram_addr <= w_host_pick ? i_host_addr : i_cpu_addr;
                r_ram_in   <= w_host_pick ? i_host_wdata : i_cpu_wdata;
                r_ram_wen  <= w_host_pick ? i_host_we : i_cpu_we;
                if (w_host_pick) begin
                    r_wait_cnt <= '0;
                end else if (w_host_elig && (r_wait_cnt != WaitMax)) begin
                    r_wait_cnt <= r_wait_cnt + WaitW'(1);
                end
            end
            if (r_state == StIssue) begin
                r_lat_cnt <= '0;
            end else if (r_state == StWait) begin
                r_lat_cnt <= r_lat_cnt + LatW'(1);
            end
            if (w_sample) begin
                if (r_host_win) r_host_rdata <= i_ram_out;
                else            r_cpu_rdata  <= i_ram_out;
            end
        end
    end

    assign o_cpu_ack    = w_done & ~r_host_win;
    assign o_host_ack   = w_done & r_host_win;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_host_rdata = r_host_rdata;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_in     = r_ram_in;
    assign o_ram_wen    = r_ram_wen;
    assign o_busy       = (r_state != StIdle);

endmodule
